// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: frames OV7670 pixels on vsync, decimates them,
// reformats RGB565 to 12-bit data and issues linear frame-buffer writes.
//
// Ports:
//   clk, reset (async, active-low)
//   capture_en, single_shot, mode[1:0]       capture control
//   vsync, pix_valid, pix_x, pix_y, pix_data camera pixel stream
//   wr_en, wr_addr, wr_data                  frame-buffer write port
//   busy, frame_done, frame_count            status
//   overrun, short_frame                     sticky error flags
module frame_capture_ctrl #(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int DECIM  = 2,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              single_shot,
  input  logic [1:0]        mode,
  input  logic              vsync,
  input  logic              pix_valid,
  input  logic [X_W-1:0]    pix_x,
  input  logic [Y_W-1:0]    pix_y,
  input  logic [15:0]       pix_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              overrun,
  output logic              short_frame
);

  localparam int SH    = $clog2(DECIM);
  localparam int HD    = H_ACT / DECIM;
  localparam int N     = HD * (V_ACT / DECIM);
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [X_W:0] H_LIM = (X_W+1)'(H_ACT);
  localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_ACT);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             vsync_q;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       fc_q, fc_d;
  logic             ovr_q, ovr_d;
  logic             short_q, short_d;

  logic vs_rise;
  logic in_win;
  logic on_grid;
  logic accept;
  logic full;
  logic px_wr;
  logic start;

  assign vs_rise = vsync & ~vsync_q;
  assign in_win  = ({1'b0, pix_x} < H_LIM) &&
                   ({1'b0, pix_y} < V_LIM);
  assign on_grid = ((pix_x & X_W'(DECIM-1)) == '0) &&
                   ((pix_y & Y_W'(DECIM-1)) == '0);
  assign accept  = (state_q == CAPTURE) & pix_valid &
                   ~vs_rise & in_win & on_grid;
  assign full    = (cnt_q == CNT_W'(N));
  // Pixels past capacity are still accepted (they flag overrun)
  // but never reach the frame buffer.
  assign px_wr   = accept & ~full;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    ovr_d   = ovr_q;
    short_d = short_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture_en) begin
          state_d = ARMED;
          ovr_d   = 1'b0;
          short_d = 1'b0;
        end
      end
      ARMED: begin
        if (!capture_en) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          state_d = CAPTURE;
          start   = 1'b1;
        end
      end
      CAPTURE: begin
        if (vs_rise) state_d = DONE;
      end
      DONE: begin
        fc_d = fc_q + 8'd1;
        if (!full) short_d = 1'b1;
        if (capture_en && !single_shot) begin
          state_d = CAPTURE;
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (accept) begin
      if (full) ovr_d = 1'b1;
      else      cnt_d = cnt_q + CNT_W'(1);
    end
    if (start) begin
      mode_d = (mode == 2'b11) ? 2'b00 : mode;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      mode_q  <= 2'b00;
      cnt_q   <= '0;
      fc_q    <= 8'd0;
      ovr_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
      ovr_q   <= ovr_d;
      short_q <= short_d;
    end
  end

  logic [4:0]        r5;
  logic [5:0]        g6;
  logic [4:0]        b5;
  logic [7:0]        sum_c;
  logic [5:0]        g_thr;
  logic [5:0]        b_thr;
  logic              red_c;
  logic [ADDR_W-1:0] addr_c;

  assign r5     = pix_data[15:11];
  assign g6     = pix_data[10:5];
  assign b5     = pix_data[4:0];
  assign sum_c  = {2'b00, r5, 1'b0} + {1'b0, g6, 1'b0} +
                  {2'b00, b5, 1'b0};
  assign g_thr  = {1'b0, g6[5:1]} + 6'd4;
  assign b_thr  = {1'b0, b5} + 6'd4;
  assign red_c  = ({1'b0, r5} >= g_thr) && ({1'b0, r5} >= b_thr);
  assign addr_c = ADDR_W'(pix_y >> SH) * ADDR_W'(HD) +
                  ADDR_W'(pix_x >> SH);

  logic              s1_v_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [3:0]        s1_g4_q;
  logic              s1_red_q;
  logic [11:0]       s1_rgb_q;
  logic [1:0]        s1_mode_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [11:0]       wr_data_q;
  logic [11:0]       grey_c;
  logic [11:0]       data_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q    <= 1'b0;
      s1_addr_q <= '0;
      s1_g4_q   <= 4'd0;
      s1_red_q  <= 1'b0;
      s1_rgb_q  <= 12'd0;
      s1_mode_q <= 2'b00;
    end else begin
      s1_v_q <= px_wr;
      if (px_wr) begin
        s1_addr_q <= addr_c;
        s1_g4_q   <= sum_c[7:4];
        s1_red_q  <= red_c;
        s1_rgb_q  <= {r5[4:1], g6[5:2], b5[4:1]};
        s1_mode_q <= mode_q;
      end
    end
  end

  always_comb begin
    grey_c = {3{s1_g4_q}};
    data_c = grey_c;
    unique case (1'b1)
      s1_mode_q == 2'b01: data_c = s1_red_q ? 12'hF00 : grey_c;
      s1_mode_q == 2'b10: data_c = s1_rgb_q;
      default:            data_c = grey_c;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 12'd0;
    end else begin
      wr_en_q <= s1_v_q;
      if (s1_v_q) begin
        wr_addr_q <= s1_addr_q;
        wr_data_q <= data_c;
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q == CAPTURE) || (state_q == DONE);
  assign frame_done  = (state_q == DONE);
  assign frame_count = fc_q;
  assign overrun     = ovr_q;
  assign short_frame = short_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl on a reduced 16x8 raster, DECIM=2
// (capacity 32 pixels, 8 decimated pixels per line).
module tb_frame_capture_ctrl;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int D  = 2;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int AW = 17;
  localparam int NP = (H / D) * (V / D);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          capture_en = 1'b0;
  logic          single_shot = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          vsync = 1'b0;
  logic          pix_valid = 1'b0;
  logic [XW-1:0] pix_x = '0;
  logic [YW-1:0] pix_y = '0;
  logic [15:0]   pix_data = 16'h0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          overrun;
  logic          short_frame;

  frame_capture_ctrl #(
    .H_ACT(H), .V_ACT(V), .DECIM(D),
    .X_W(XW), .Y_W(YW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .capture_en(capture_en), .single_shot(single_shot),
    .mode(mode), .vsync(vsync), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .overrun(overrun),
    .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int exp_fc = 0;

  always @(negedge clk) if (wr_en) wr_cnt++;

  typedef struct {
    logic [1:0]  m;
    int          x;
    int          y;
    logic [15:0] d;
    bit          w;
    int          a;
    logic [11:0] q;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
  endtask

  task automatic drive(input int x, input int y, input logic [15:0] d);
    pix_x     = XW'(x);
    pix_y     = YW'(y);
    pix_data  = d;
    pix_valid = 1'b1;
  endtask

  // End the running frame and start the next one with mode m,
  // then scramble the mode input to show it is latched.
  task automatic new_frame(input logic [1:0] m);
    mode = m;
    vs_pulse();
    chk("frame_done", frame_done, 1);
    exp_fc++;
    step();
    chk("frame_count", frame_count, exp_fc);
    chk("busy_next", busy, 1);
    mode = m ^ 2'b01;
  endtask

  task automatic raster();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        drive(x, y, 16'hFFFF);
        step();
      end
    pix_valid = 1'b0;
  endtask

  logic [31:0]   acc;
  int            ea;
  int            w0;
  int            nw;
  logic [AW-1:0] la;
  logic [11:0]   ld;
  logic [1:0]    cur_m;

  initial begin
    tv[0]  = '{2'b00,  0, 0, 16'hFFFF, 1, 0,  12'hFFF};
    tv[1]  = '{2'b00,  4, 2, 16'h07E0, 1, 10, 12'h777};
    tv[2]  = '{2'b00,  8, 0, 16'hF800, 1, 4,  12'h333};
    tv[3]  = '{2'b00, 14, 6, 16'h1234, 1, 31, 12'h444};
    tv[4]  = '{2'b00,  3, 2, 16'hFFFF, 0, 0,  12'h000};
    tv[5]  = '{2'b00,  2, 3, 16'hFFFF, 0, 0,  12'h000};
    tv[6]  = '{2'b00, 16, 0, 16'hFFFF, 0, 0,  12'h000};
    tv[7]  = '{2'b00,  0, 8, 16'hFFFF, 0, 0,  12'h000};
    tv[8]  = '{2'b01,  2, 0, 16'hF800, 1, 1,  12'hF00};
    tv[9]  = '{2'b01,  0, 2, 16'h07E0, 1, 8,  12'h777};
    tv[10] = '{2'b01,  6, 4, 16'hF81F, 1, 19, 12'h777};
    tv[11] = '{2'b01,  8, 6, 16'h4104, 1, 28, 12'hF00};
    tv[12] = '{2'b01, 10, 6, 16'h3904, 1, 29, 12'h222};
    tv[13] = '{2'b10,  0, 0, 16'h1234, 1, 0,  12'h14A};
    tv[14] = '{2'b10, 12, 4, 16'hFFFF, 1, 22, 12'hFFF};
    tv[15] = '{2'b10,  2, 2, 16'hF81F, 1, 9,  12'hF0F};
    tv[16] = '{2'b11,  0, 0, 16'h07E0, 1, 0,  12'h777};
    tv[17] = '{2'b11,  4, 4, 16'h0000, 1, 18, 12'h000};

    // reset and idle behaviour
    #1 reset = 1'b0;
    #3;
    chk("reset_outs", {wr_en, busy, frame_done, overrun,
        short_frame, frame_count, wr_data}, 0);
    chk("reset_addr", wr_addr, 0);
    step();
    reset = 1'b1;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      vsync = ~vsync;
      step();
      acc |= {wr_en, busy, frame_done, overrun, short_frame,
              frame_count, wr_data};
      acc |= 32'(wr_addr);
    end
    chk("idle_quiet", acc, 0);
    vsync = 1'b0;
    step();

    // full decimated frame, grey
    capture_en = 1'b1;
    step();
    chk("armed_not_busy", busy, 0);
    vs_pulse();
    chk("capture_busy", busy, 1);
    mode = 2'b01;
    ea = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        drive(x, y, 16'hFFFF);
        step();
        if (wr_en) begin
          chk("burst_addr", wr_addr, ea);
          chk("burst_data", wr_data, 12'hFFF);
          ea++;
        end
      end
    pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wr_en) begin
        chk("burst_addr", wr_addr, ea);
        chk("burst_data", wr_data, 12'hFFF);
        ea++;
      end
    end
    chk("burst_count", ea, NP);

    // per-pixel vectors, one frame per mode
    new_frame(tv[0].m);
    chk("full_no_short", short_frame, 0);
    chk("full_no_ovr", overrun, 0);
    cur_m = tv[0].m;
    la = AW'(NP - 1);
    ld = 12'hFFF;
    for (int i = 0; i < 18; i++) begin
      if (tv[i].m != cur_m) begin
        new_frame(tv[i].m);
        cur_m = tv[i].m;
      end
      drive(tv[i].x, tv[i].y, tv[i].d);
      step();
      pix_valid = 1'b0;
      step();
      chk($sformatf("v%0d_wr_en", i), wr_en, tv[i].w);
      if (tv[i].w) begin
        la = AW'(tv[i].a);
        ld = tv[i].q;
      end
      chk($sformatf("v%0d_addr", i), wr_addr, la);
      chk($sformatf("v%0d_data", i), wr_data, ld);
      step();
      chk($sformatf("v%0d_wr_off", i), wr_en, 0);
    end
    capture_en = 1'b0;
    vs_pulse();
    chk("frame_done", frame_done, 1);
    exp_fc++;
    step();
    chk("frame_count", frame_count, exp_fc);
    chk("short_set", short_frame, 1);
    chk("to_idle", busy, 0);

    // overrun, then a short frame
    capture_en = 1'b1;
    step();
    chk("arm_clears_short", short_frame, 0);
    mode = 2'b00;
    vs_pulse();
    w0 = wr_cnt;
    raster();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 16'h0000);
      step();
    end
    pix_valid = 1'b0;
    step();
    step();
    step();
    chk("ovr_writes", wr_cnt - w0, NP);
    chk("ovr_flag", overrun, 1);
    new_frame(2'b00);
    chk("exact_no_short", short_frame, 0);
    chk("ovr_sticky", overrun, 1);
    for (int i = 0; i < 5; i++) begin
      drive(2 * i, 0, 16'h1111);
      step();
    end
    pix_valid = 1'b0;
    new_frame(2'b00);
    chk("short_flag", short_frame, 1);

    // asynchronous reset mid-frame
    nw = 0;
    for (int i = 0; i < 64 && nw < 10; i++) begin
      drive(i % H, i / H, 16'hFFFF);
      step();
      if (wr_en) nw++;
    end
    chk("rst_prewrites", nw, 10);
    reset = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", frame_count, 0);
    step();
    chk("rst_wr_en_edge", wr_en, 0);
    pix_valid = 1'b0;
    reset = 1'b1;
    exp_fc = 0;
    step();
    chk("rst_idle", busy, 0);

    // single shot; capture_en drops mid-frame
    single_shot = 1'b1;
    mode = 2'b10;
    step();
    vs_pulse();
    chk("ss_capture", busy, 1);
    capture_en = 1'b0;
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(2 * i, 0, 16'hABCD);
      step();
    end
    drive(8, 0, 16'hABCD);
    vs_pulse();
    pix_valid = 1'b0;
    chk("ss_done", frame_done, 1);
    exp_fc++;
    step();
    chk("ss_idle", busy, 0);
    chk("ss_fc", frame_count, exp_fc);
    step();
    step();
    chk("ss_writes", wr_cnt - w0, 4);
    drive(10, 0, 16'hABCD);
    vs_pulse();
    for (int i = 0; i < 4; i++) begin
      drive(2 * i, 2, 16'hABCD);
      step();
    end
    pix_valid = 1'b0;
    step();
    step();
    chk("ss_third_idle", busy, 0);
    chk("ss_third_writes", wr_cnt - w0, 4);
    chk("ss_fc_hold", frame_count, exp_fc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
